// File: rtl/race_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : race_mem_pkg
// Desc   : Shared types and helpers for the race-logic memory array.
// Rev    : 1.0  initial release
// ============================================================================
package race_mem_pkg;

  // Widest gamma-count field a cell can hold; G may not exceed 2**T_W.
  localparam int unsigned T_W = 16;

  function automatic int unsigned CNT_W(input int unsigned g);
    return $clog2(g);
  endfunction

  typedef enum logic {
    MODE_REPLAY = 1'b0,
    MODE_DELAY  = 1'b1
  } mode_e;

  typedef struct packed {
    logic [T_W-1:0] capture_t;
    logic           capture_v;
    logic [T_W-1:0] replay_t;
    logic           replay_v;
    logic [T_W-1:0] active_d;
    logic [T_W-1:0] shadow_d;
  } cell_state_t;

endpackage
`default_nettype wire

// File: rtl/race_mem_cell.sv
`default_nettype none
// ============================================================================
// Module : race_mem_cell
// Desc   : One channel: edge detect, first-edge capture, replay/delay pulse.
// Rev    : 1.0  initial release
// ============================================================================
module race_mem_cell
  import race_mem_pkg::*;
#(
  parameter int unsigned PULSE_WIDTH = 8,
  parameter int unsigned CNT_BITS    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                boundary_i,
  input  logic [CNT_BITS-1:0] cnt_i,
  input  logic [CNT_BITS-1:0] cnt_d_i,
  input  mode_e               mode_d_i,
  input  logic                in_i,
  input  logic                we_i,
  input  logic [CNT_BITS-1:0] delay_i,
  output logic                out_o
);

  localparam int unsigned EW = T_W + 1;

  cell_state_t    st_q, st_d;
  logic           in_q;
  logic           out_q, out_d;
  logic           rise;
  logic           cap_v;
  logic [T_W-1:0] cap_t;
  logic [EW-1:0]  c_ext;
  logic [EW-1:0]  start;
  logic           win_v;

  assign rise = in_i & ~in_q;

  // Capture view including an edge in this very cycle, so a rise in the
  // boundary cycle still commits into the replay slot.
  always_comb begin
    st_d  = st_q;
    cap_v = st_q.capture_v | rise;
    cap_t = st_q.capture_v ? st_q.capture_t : T_W'(cnt_i);
    if (boundary_i) begin
      st_d.replay_t  = cap_t;
      st_d.replay_v  = cap_v;
      st_d.capture_v = 1'b0;
      st_d.active_d  = st_q.shadow_d;
    end else begin
      st_d.capture_t = cap_t;
      st_d.capture_v = cap_v;
    end
    if (we_i) begin
      st_d.shadow_d = T_W'(delay_i);
    end
  end

  // Output is evaluated against next-cycle state so the registered pulse
  // lines up with the count shown in the same cycle.
  always_comb begin
    c_ext = EW'(cnt_d_i);
    if (mode_d_i == MODE_REPLAY) begin
      win_v = st_d.replay_v;
      start = {1'b0, st_d.replay_t};
    end else begin
      win_v = st_d.capture_v;
      start = {1'b0, st_d.capture_t} + {1'b0, st_d.active_d} + EW'(1);
    end
    out_d = win_v && (c_ext >= start) && ((c_ext - start) < EW'(PULSE_WIDTH));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q  <= '0;
      in_q  <= 1'b0;
      out_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      in_q  <= in_i;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule
`default_nettype wire

// File: rtl/race_mem_array.sv
`default_nettype none
// ============================================================================
// Module : race_mem_array
// Desc   : Gamma-cycle race-logic memory: shared counter plus WIDTH cells.
// Rev    : 1.0  initial release
// ============================================================================
module race_mem_array
  import race_mem_pkg::*;
#(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PULSE_WIDTH       = 8,
  parameter int unsigned WIDTH             = 128
) (
  input  logic                                 aclk,
  input  logic                                 rst,
  input  logic                                 grst,
  input  logic                                 mode,
  input  logic [WIDTH-1:0]                     in,
  output logic [WIDTH-1:0]                     out,
  input  logic                                 cfg_we,
  input  logic [$clog2(WIDTH)-1:0]             cfg_addr,
  input  logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] cfg_delay,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] gamma_cnt
);

  localparam int unsigned         CNT_BITS = CNT_W(GAMMA_CYCLE_WIDTH);
  localparam int unsigned         AW       = $clog2(WIDTH);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(GAMMA_CYCLE_WIDTH - 1);

  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                boundary;
  mode_e               mode_q, mode_d;

  always_comb begin
    if (grst || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign boundary = (cnt_d == '0);
  assign mode_d   = boundary ? mode_e'(mode) : mode_q;

  always_ff @(posedge aclk) begin
    if (rst) begin
      cnt_q  <= '0;
      mode_q <= MODE_REPLAY;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  assign gamma_cnt = cnt_q;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic we;
      assign we = cfg_we && (cfg_addr == AW'(i));

      race_mem_cell #(
        .PULSE_WIDTH (PULSE_WIDTH),
        .CNT_BITS    (CNT_BITS)
      ) u_cell (
        .clk_i      (aclk),
        .rst_i      (rst),
        .boundary_i (boundary),
        .cnt_i      (cnt_q),
        .cnt_d_i    (cnt_d),
        .mode_d_i   (mode_d),
        .in_i       (in[i]),
        .we_i       (we),
        .delay_i    (cfg_delay),
        .out_o      (out[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/race_mem_array.md
Name: race_mem_array

Overview:
- Parametrised successor to the shared-counter race-logic memory group.
- Each of WIDTH channels captures the gamma-cycle arrival time of the first rising edge on its input.
- Mode 0 (replay): re-emits that edge as a PULSE_WIDTH pulse at the same time in the next gamma cycle.
- Mode 1 (delay): emits the pulse in the same gamma cycle, delayed by a per-channel programmable amount.
- Sits between temporal-coded neuron columns; one shared gamma counter.

Parameters:
- GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle G; power of 2, ≥4.
- PULSE_WIDTH, 8, output pulse length in cycles, 1..G.
- WIDTH, 128, channel count, ≥2.

Ports:
- aclk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- grst  in  1  gamma-cycle start; forces counter to 0 next cycle.
- mode  in  1  0 = replay, 1 = programmable delay; sampled at gamma boundary.
- in  in  WIDTH  rising-edge temporal inputs.
- out  out  WIDTH  registered output pulses.
- cfg_we  in  1  delay write strobe.
- cfg_addr  in  $clog2(WIDTH)  channel index.
- cfg_delay  in  $clog2(G)  delay value d.
- gamma_cnt  out  $clog2(G)  current counter value c.

Interface decision: one clock (aclk); reset (rst) is synchronous and active-high.

Behaviour:
- Reset (rst): counter=0, out=0, in_q=0, all capture/replay valid bits=0, shadow and active delays=0, mode_q=0. rst beats grst and cfg_we.
- Counter: c wraps G-1→0. grst loads 0. Boundary = any clock edge where c becomes 0, by wrap or grst.
- At each boundary:
  - active_delay ← shadow_delay.
  - mode_q ← mode.
  - replay_t/valid ← capture_t/valid.
  - capture valid cleared.
  - pending mode-1 pulses discarded.
- Edge detection: rise[i] = in[i] & ~in_q[i]; in_q registered every cycle.
  - Input held high across a boundary is not a new edge.
  - High input right after rst is an edge.
- Capture: first rise per channel per gamma cycle stores t=c and sets valid. Later rises in the same gamma cycle are ignored. A rise at c=G-1 is captured.
- Mode 0: out[i]=1 exactly during cycles with replay_valid and replay_t ≤ c < min(replay_t+PULSE_WIDTH, G). Pulses are clipped at the gamma end, never wrapping. Latency is exactly one gamma cycle.
- Mode 1: rise at count t schedules out[i]=1 during counts t+1+d ≤ c < min(t+1+d+PULSE_WIDTH, G).
  - If t+1+d ≥ G, no pulse.
  - Only the first rise per gamma cycle is used.
- Config: cfg_we writes shadow[cfg_addr]; it takes effect at the next boundary. A write in the boundary cycle itself lands in shadow only and takes effect one boundary later. Out-of-range cfg_addr is ignored.
- grst mid-gamma: treated as a normal boundary (commit and replay start), so a truncated gamma cycle still replays.
- rst mid-operation: out=0 the next cycle; the following gamma cycle emits nothing.
- Widths: all time arithmetic uses $clog2(G)+1 bits to detect overflow past G-1.

Decomposition:
- Package race_mem_pkg:
  - CNT_W function ($clog2).
  - mode_e enum {MODE_REPLAY, MODE_DELAY}.
  - Per-channel cell state struct {capture_t, capture_v, replay_t, replay_v, active_d, shadow_d}.
- Top holds the counter, boundary logic, mode_q and config decode.
- Sub-module race_mem_cell, one instance per channel: edge detect, capture, replay/delay compare, out register.

Test Plan (G=16, PW=4, WIDTH=8):
1. rst, grst; in[0] rises at c=5 → next gamma out[0]=1 for c=5..8 only; no output in the capture gamma.
2. in[1] rises at c=14 → next gamma out[1]=1 at c=14,15 only (clipped); in[2] rises at c=15 → next gamma out[2]=1 at c=15 only.
3. in[3] rises at c=2, falls, rises at c=9 → replay pulse at c=2..5 only.
4. mode=1 at boundary, delay ch4=3 written in prior gamma; in[4] rise at c=2 → out[4]=1 c=6..9 same gamma. Write delay=0 mid-gamma → unchanged until after the next boundary. Rise at c=13 with d=3 → no pulse.
5. grst asserted at c=9 after in[5] rose at c=4 → counter 0 next cycle; out[5]=1 at c=4..7 of the new gamma.
6. rst asserted at c=6 while out[0] pulsing → out=0 next cycle; captured edges discarded; no replay in the following gamma; gamma_cnt=0.
